// File: rtl/sprite_ram_loader.sv
// Sprite RAM write-side loader: validates a target window, then copies a raster-ordered
// valid/ready pixel stream into consecutive RAM words with a fixed one-cycle write latency.
module sprite_ram_loader #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24,
    parameter int DIM_W  = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  sprite_width,
    input  logic [DIM_W-1:0]  sprite_height,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] data_in,
    output logic              we,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int PROD_W = 2 * DIM_W;
    localparam int SUM_W  = (((ADDR_W + 1) > PROD_W) ? (ADDR_W + 1) : PROD_W) + 1;
    localparam logic [SUM_W-1:0]  ADDR_LIMIT = {{(SUM_W-1){1'b0}}, 1'b1} << ADDR_W;
    localparam logic [DIM_W-1:0]  DIM_ONE    = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   base_r;
    logic [DIM_W-1:0]    w_r;
    logic [DIM_W-1:0]    h_r;
    logic [DIM_W-1:0]    col_r;
    logic [DIM_W-1:0]    row_r;
    logic [ADDR_W-1:0]   offset_r;
    logic                pix_ready_r;
    logic                we_r;
    logic [ADDR_W-1:0]   write_address_r;
    logic [DATA_W-1:0]   data_in_r;
    logic                busy_r;
    logic                done_r;
    logic                error_r;

    logic [PROD_W-1:0]   prod_s;
    logic [SUM_W-1:0]    end_s;
    logic                bad_s;
    logic                accept_s;
    logic                last_col_s;
    logic                last_beat_s;

    // Window check and beat-position decode; the end address is formed wide enough never to wrap
    always_comb begin
        prod_s      = {{DIM_W{1'b0}}, w_r} * {{DIM_W{1'b0}}, h_r};
        end_s       = {{(SUM_W-ADDR_W){1'b0}}, base_r} + {{(SUM_W-PROD_W){1'b0}}, prod_s};
        bad_s       = (w_r == {DIM_W{1'b0}}) || (h_r == {DIM_W{1'b0}}) || (end_s > ADDR_LIMIT);
        accept_s    = pix_valid && pix_ready_r;
        last_col_s  = (col_r == (w_r - DIM_ONE));
        last_beat_s = last_col_s && (row_r == (h_r - DIM_ONE));
    end

    // Loader FSM with all outputs registered
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r         <= ST_IDLE;
            base_r          <= '0;
            w_r             <= '0;
            h_r             <= '0;
            col_r           <= '0;
            row_r           <= '0;
            offset_r        <= '0;
            pix_ready_r     <= 1'b0;
            we_r            <= 1'b0;
            write_address_r <= '0;
            data_in_r       <= '0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            error_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    we_r        <= 1'b0;
                    done_r      <= 1'b0;
                    error_r     <= 1'b0;
                    pix_ready_r <= 1'b0;
                    if (load_start) begin
                        base_r  <= base_addr;
                        w_r     <= sprite_width;
                        h_r     <= sprite_height;
                        busy_r  <= 1'b1;
                        state_r <= ST_CHECK;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (bad_s) begin
                        state_r <= ST_ERROR;
                    end else begin
                        col_r       <= '0;
                        row_r       <= '0;
                        offset_r    <= '0;
                        pix_ready_r <= 1'b1;
                        state_r     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // A beat taken on the abort edge is still written out
                    if (accept_s) begin
                        we_r            <= 1'b1;
                        write_address_r <= base_r + offset_r;
                        data_in_r       <= pix_data;
                        offset_r        <= offset_r + ADDR_ONE;
                        if (last_col_s) begin
                            col_r <= '0;
                            row_r <= row_r + DIM_ONE;
                        end else begin
                            col_r <= col_r + DIM_ONE;
                        end
                    end else begin
                        we_r <= 1'b0;
                    end
                    if (abort) begin
                        pix_ready_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (accept_s && last_beat_s) begin
                        pix_ready_r <= 1'b0;
                        state_r     <= ST_DRAIN;
                    end else begin
                        state_r     <= ST_LOAD;
                    end
                end
                ST_DRAIN: begin
                    we_r    <= 1'b0;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_ERROR: begin
                    error_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    pix_ready_r <= 1'b0;
                    we_r        <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    error_r     <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign pix_ready     = pix_ready_r;
    assign we            = we_r;
    assign write_address = write_address_r;
    assign data_in       = data_in_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;

endmodule

// File: doc/sprite_ram_loader.md
Name: sprite_ram_loader

Overview:
- Write-side counterpart of the sprite renderers: fills a sprite RAM region in raster order from a valid/ready pixel stream.
- Source is a boot-time ROM walker or a host byte-assembler.
- Drives the RAM's write port (write_address, data_in, we) that the renderers leave tied off; renderers only read.
- Signals done so game logic can assert start to the renderers once the sprite image is resident.

Parameters:
- ADDR_W, 19, RAM word address width.
- DATA_W, 24, pixel width ({R,G,B} 8 bits each).
- DIM_W, 10, width/height field width.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle request; samples base_addr/sprite_width/sprite_height.
- base_addr  in  ADDR_W  RAM word address of pixel (0,0).
- sprite_width  in  DIM_W  columns per row, 1..1023.
- sprite_height  in  DIM_W  rows, 1..1023.
- abort  in  1  synchronous cancel of an active load.
- pix_valid  in  1  stream beat valid.
- pix_data  in  DATA_W  pixel value, raster order (row 0 col 0 first).
- pix_ready  out  1  loader accepts beat this cycle.
- write_address  out  ADDR_W  RAM write address.
- data_in  out  DATA_W  RAM write data.
- we  out  1  RAM write enable, one word per cycle.
- busy  out  1  high from accepted load_start until DONE/ERROR exit.
- done  out  1  one-cycle pulse after last word written.
- error  out  1  one-cycle pulse on rejected request.

Behaviour:
- Reset (Reset_n low, async): state IDLE; pix_ready, we, busy, done, error = 0; write_address, data_in, col, row, offset = 0. Release is synchronous to Clk.
- States: IDLE, CHECK, LOAD, DRAIN, DONE, ERROR.
- IDLE:
  - load_start=1 latches base/width/height into w_r/h_r/base_r and goes to CHECK; busy=1 from the next cycle.
  - load_start while not IDLE is ignored.
- CHECK (1 cycle): compute end = base_r + w_r*h_r at ADDR_W+1 bits.
  - w_r==0, h_r==0, or end > 2**ADDR_W goes to ERROR.
  - Otherwise clear col/row/offset and go to LOAD.
- LOAD:
  - pix_ready=1.
  - Beat accepted when pix_valid & pix_ready.
  - Registered write on the cycle after acceptance: we=1, write_address=base_r+offset (offset as sampled at acceptance), data_in=pix_data. Write latency = exactly 1 cycle.
  - On accept: offset+=1, col+=1. When col==w_r-1, col goes to 0 and row+=1 on the same edge.
  - No beat: we=0 next cycle, counters hold. Gaps in pix_valid are legal at any point.
  - Accepting the beat with col==w_r-1 and row==h_r-1 goes to DRAIN; pix_ready drops the same edge. Total accepted beats = w_r*h_r exactly; no extra beat is consumed.
- DRAIN (1 cycle): last write issued (we=1). Go to DONE.
- DONE (1 cycle): done=1, busy=0, go to IDLE.
- ERROR (1 cycle): error=1, busy=0, no writes ever issued, go to IDLE.
- abort=1 in CHECK or LOAD:
  - Go to IDLE next edge; pix_ready=0 that edge; done/error are not pulsed.
  - A beat accepted on the same edge as abort is still written (we=1 the following cycle).
  - Already-written words are not undone.
- abort in IDLE, DONE or ERROR has no effect.
- Arithmetic:
  - offset is ADDR_W bits, unsigned.
  - Address addition cannot wrap, because CHECK guarantees end <= 2**ADDR_W.
  - w_r*h_r is computed at 2*DIM_W bits before the compare.
- When we=0, write_address and data_in hold their last values (no spurious toggling required).
- Reset asserted mid-LOAD: we drops immediately (async); no partial-cycle write is guaranteed.

Test Plan:
- Reset, then load_start with base=0x100, w=50, h=44, pix_valid held 1, pix_data=incrementing index -> 2200 writes.
  - First write: addr 0x100, data 0, one cycle after first accept.
  - Last write: addr 0x100+2199=0x997.
  - done pulses exactly 2 cycles after last accept; busy low the same cycle.
- w=3, h=2, pix_valid random 50% duty -> exactly 6 writes at base..base+5 in order; no write on gap cycles; pix_ready low after 6th accept.
- w=0 or h=0; also base=0x7FFF0 with w=16, h=2 (end 0x80010 > 0x80000) -> error pulse after 2 cycles, we never high, busy 1 for 2 cycles.
- base=0x7FFF0, w=16, h=1 (end exactly 0x80000) -> accepted; 16 writes ending at 0x7FFFF; done pulses.
- abort asserted after 10th accept in a 4x4 load -> 10 writes total, no done/error, back in IDLE. A following load_start is accepted normally.
- Reset_n pulsed low mid-LOAD -> all outputs 0 asynchronously; after release, loader in IDLE and ignores stray pix_valid.
